// File: rtl/fir_stream_ctrl.sv
// Purpose : valid/ready stream sequencer for one fir_filter; turns both stream handshakes into the filter enable.
// Latency : a sample accepted on advance n is presented (m_valid_o=1) after advance n+LAT-1; no extra output register.
// Backpr. : a held, unconsumed output stalls the whole filter (fir_en_o=0, s_ready_o=0, m_data_o stable).
//
// Ports:
//   clk_i, arstn_i          clock; synchronous active-low reset, shared with the driven fir_filter
//   s_valid_i/s_ready_o/s_data_i    input sample stream (signed DATA_WIDTH)
//   m_valid_o/m_ready_i/m_data_o    output sample stream (signed OUT_WIDTH, bit-exact copy of fir_data_i)
//   flush_i                 flush request, sampled in RUN only
//   busy_o                  high while flushing
//   flush_done_o            one-cycle pulse when a flush completes
//   fir_en_o/fir_data_o/fir_data_i  filter enable, filter input sample, filter output
//
// Build option: define FIR_STREAM_CTRL_STAT_EN to add in_cnt_o / out_cnt_o transfer counters
// (32-bit, wrapping, reset to 0, not cleared by flush). Without it those ports do not exist.

module fir_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int COE_NUM    = 66
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [OUT_WIDTH-1:0]  m_data_o,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  flush_done_o,
    output logic                  fir_en_o,
    output logic [DATA_WIDTH-1:0] fir_data_o,
    input  logic [OUT_WIDTH-1:0]  fir_data_i
`ifdef FIR_STREAM_CTRL_STAT_EN
    ,
    output logic [31:0]           in_cnt_o,
    output logic [31:0]           out_cnt_o
`endif
);

    // Filter latency in enables, input to data_o.
    localparam int LAT = COE_NUM + 1;
    localparam int CW  = $clog2(LAT + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]     state_q;
    logic [LAT-1:0] tag_q;        // tag_q[i]=1: filter stage i carries a real sample
    logic [CW-1:0]  flush_cnt_q;  // zero advances still to insert while flushing
    logic           busy_q;
    logic           flush_done_q;

    logic run;
    logic out_free;
    logic advance;
    logic out_xfer;

    assign run      = (state_q == ST_RUN);
    assign m_valid_o = tag_q[LAT-1];

    // The output slot can move on if it is empty or is being taken this cycle.
    assign out_free = !m_valid_o | m_ready_i;
    assign out_xfer = m_valid_o & m_ready_i;

    // One advance = one filter enable. In FLUSH the filter is clocked with zeros
    // regardless of the input stream; the reset gating keeps the filter frozen
    // while it is itself being reset.
    always_comb begin
        advance = 1'b0;
        if (arstn_i) begin
            if (run) begin
                advance = s_valid_i & out_free;
            end else begin
                advance = out_free;
            end
        end
    end

    assign fir_en_o     = advance;
    assign s_ready_o    = arstn_i & run & out_free;
    assign fir_data_o   = run ? s_data_i : '0;
    assign m_data_o     = fir_data_i;
    assign busy_o       = busy_q;
    assign flush_done_o = flush_done_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q      <= ST_RUN;
            tag_q        <= '0;
            flush_cnt_q  <= '0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;

            // Tags travel with the data through the filter; flush zeros get tag 0.
            // Without an advance the output sample stays in the filter's last sum
            // register, so a consumed output only clears its tag.
            if (advance) begin
                tag_q <= {tag_q[LAT-2:0], run};
            end else if (out_xfer) begin
                tag_q[LAT-1] <= 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    // The input handshake of this same cycle still completes above.
                    if (flush_i) begin
                        state_q     <= ST_FLUSH;
                        busy_q      <= 1'b1;
                        flush_cnt_q <= CW'(LAT);
                    end
                end
                ST_FLUSH: begin
                    // LAT zero advances push every real sample out and leave all
                    // history stages at zero.
                    if (advance) begin
                        if (flush_cnt_q == CW'(1)) begin
                            state_q      <= ST_RUN;
                            busy_q       <= 1'b0;
                            flush_done_q <= 1'b1;
                            flush_cnt_q  <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIR_STREAM_CTRL_STAT_EN
    logic [31:0] in_cnt_q;
    logic [31:0] out_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (s_valid_i & s_ready_o) begin
                in_cnt_q <= in_cnt_q + 32'd1;
            end
            if (out_xfer) begin
                out_cnt_q <= out_cnt_q + 32'd1;
            end
        end
    end

    assign in_cnt_o  = in_cnt_q;
    assign out_cnt_o = out_cnt_q;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
module tb_fir_stream_ctrl;

    localparam int DW  = 16;
    localparam int OW  = 32;
    localparam int CN  = 4;
    localparam int LAT = CN + 1;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_data;
    logic          flush = 1'b0;
    logic          busy;
    logic          flush_done;
    logic          fir_en;
    logic [DW-1:0] fir_data_o;
    logic [OW-1:0] fir_data_i;
`ifdef FIR_STREAM_CTRL_STAT_EN
    logic [31:0]   in_cnt;
    logic [31:0]   out_cnt;
`endif

    always #5 clk = ~clk;

    fir_stream_ctrl #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .COE_NUM(CN)) dut (
        .clk_i(clk), .arstn_i(arstn),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .flush_i(flush), .busy_o(busy), .flush_done_o(flush_done),
        .fir_en_o(fir_en), .fir_data_o(fir_data_o), .fir_data_i(fir_data_i)
`ifdef FIR_STREAM_CTRL_STAT_EN
        , .in_cnt_o(in_cnt), .out_cnt_o(out_cnt)
`endif
    );

    // Stand-in fir_filter: coefficients {1,2,3,4}, LAT-deep output pipeline.
    int h0, h1, h2;
    int pipe [LAT];
    assign fir_data_i = pipe[LAT-1];

    always @(posedge clk) begin
        if (!arstn) begin
            h0 <= 0; h1 <= 0; h2 <= 0;
            for (int k = 0; k < LAT; k++) pipe[k] <= 0;
        end else if (fir_en) begin
            h0 <= int'($signed(fir_data_o));
            h1 <= h0;
            h2 <= h1;
            pipe[0] <= int'($signed(fir_data_o)) + 2 * h0 + 3 * h1 + 4 * h2;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    int checks = 0;
    int passed = 0;
    int exp_q[$];
    int fd_cnt = 0;
    int out_seen = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Monitor: a transfer happens at the next posedge when valid&ready hold mid-cycle.
    always @(negedge clk) begin
        if (arstn && m_valid && m_ready) begin
            out_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'($signed(m_data)), -1);
            end else begin
                chk("out_data", int'($signed(m_data)), exp_q.pop_front());
            end
        end
        if (flush_done) fd_cnt++;
    end

    // Offer one sample; push its hand-computed expected output once accepted.
    task automatic send(input int x, input int expv);
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = DW'(x);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            exp_q.push_back(expv);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Request a flush and follow it to completion, counting zero advances.
    task automatic do_flush();
        int adv = 0;
        int fd0;
        bit done = 0;
        s_valid = 1'b0;
        s_data  = 16'h1234;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fd0 = fd_cnt;
        @(negedge clk);
        chk("flush_busy", int'(busy), 1);
        chk("flush_zero_data", int'(fir_data_o), 0);
        for (int i = 0; i < 200; i++) begin
            if (busy && fir_en) adv++;
            if (flush_done) begin done = 1; break; end
            @(negedge clk);
        end
        chk("flush_done_seen", int'(done), 1);
        chk("flush_advances", adv, LAT);
        chk("flush_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("flush_done_pulse", fd_cnt - fd0, 1);
        chk("flush_busy_clear", int'(busy), 0);
        @(posedge clk); #1;
    endtask

    function automatic int dc_exp(input int n);
        // DC input of 1 through taps {1,2,3,4}: 1, 3, 6, then 10.
        case (n)
            1: return 1;
            2: return 3;
            3: return 6;
            default: return 10;
        endcase
    endfunction

    int held;
    int gap;
    int fd_before;
    int x4[3] = '{2, -1, 5};
    int e4[3] = '{2, 3, 9};

    initial begin
        // 1: reset
        s_valid = 1'b1;
        s_data  = 16'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_fir_en", int'(fir_en), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        arstn   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", int'(s_ready), 1);
        @(posedge clk); #1;

        // 2: DC stream, m_valid rises with the 5th accepted sample
        for (int n = 1; n <= 8; n++) begin
            send(1, dc_exp(n));
            chk("dc_m_valid", int'(m_valid), (n >= LAT) ? 1 : 0);
        end

        // 3: backpressure for 7 cycles with input still offered
        s_valid = 1'b1;
        s_data  = 16'd1;
        m_ready = 1'b0;
        gap = 8 - out_seen;
        @(negedge clk);
        held = int'($signed(m_data));
        chk("stall_m_valid", int'(m_valid), 1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (fir_en || s_ready || int'($signed(m_data)) != held) begin
                chk("stall_hold", 0, 1);
            end
        end
        chk("stall_gap", 8 - out_seen, gap);
        chk("stall_data", held, 10);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int n = 9; n <= 14; n++) send(1, dc_exp(n));
        do_flush();
        chk("dc_one_per_input", out_seen, 14);

        // 4: three samples from cleared history, flush, then x=7 from zero history
        for (int i = 0; i < 3; i++) send(x4[i], e4[i]);
        do_flush();
        send(7, 7);
        do_flush();
        chk("post_flush_outputs", out_seen, 18);

        // 5: reset after two flush advances
        send(1, 1);
        send(1, 3);
        s_valid = 1'b0;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fd_before = fd_cnt;
        begin
            int adv = 0;
            for (int i = 0; i < 50 && adv < 2; i++) begin
                @(negedge clk);
                if (busy && fir_en) adv++;
            end
            chk("mid_flush_adv", adv, 2);
        end
        @(posedge clk); #1;
        arstn = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_m_valid", int'(m_valid), 0);
        @(posedge clk); #1;
        arstn = 1'b1;
        idle(3);
        chk("midrst_no_done", fd_cnt - fd_before, 0);
        chk("midrst_out_seen", out_seen, 18);
        send(3, 3);
        do_flush();
        chk("restart_outputs", out_seen, 19);

`ifdef FIR_STREAM_CTRL_STAT_EN
        // 6: transfer counters
        arstn = 1'b0;
        idle(2);
        arstn = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 100; n++) send(1, dc_exp(n));
        idle(2);
        chk("stat_in", int'(in_cnt), 100);
        chk("stat_out", int'(out_cnt), 96);
        do_flush();
        chk("stat_out_flushed", int'(out_cnt), 100);
        chk("stat_in_kept", int'(in_cnt), 100);
`endif

        idle(2);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
